ps_cond_unit: RTL and testbench

//  Program-sequencer condition unit: owns the ASTAT flag register and the loop counter,
//  and evaluates instruction condition codes against them. Captures ALU/MUL/SHF flags,

---
 rtl/ps_cond_unit_if.sv | 46 ++++
 rtl/ps_cond_unit.sv | 162 ++++++++++++++++
 tb/tb_ps_cond_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps_cond_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps_cond_unit_if
//  Description : Flag, loop-counter and condition bus between the execute stage,
//                the sequencer and the condition unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps_cond_unit_if #(
    parameter int NFLAGS = 10,
    parameter int CNDW   = 5,
    parameter int LCW    = 16
);
    logic              hold;
    logic              cnd_en;
    logic [CNDW-1:0]   op_cnd;
    logic              astat_wen;
    logic [NFLAGS-1:0] astat_wdata;
    logic              alu_flg_en;
    logic [3:0]        alu_flg;
    logic              mul_flg_en;
    logic [1:0]        mul_flg;
    logic              shf_flg_en;
    logic [1:0]        shf_flg;
    logic              lc_load;
    logic [LCW-1:0]    lc_ld_val;
    logic              lc_dec;
    logic [NFLAGS-1:0] astat;
    logic              lce;
    logic              cnd_stat;
    logic              cnd_vld;

    modport master (
        output hold, cnd_en, op_cnd, astat_wen, astat_wdata,
               alu_flg_en, alu_flg, mul_flg_en, mul_flg, shf_flg_en, shf_flg,
               lc_load, lc_ld_val, lc_dec,
        input  astat, lce, cnd_stat, cnd_vld
    );

    modport slave (
        input  hold, cnd_en, op_cnd, astat_wen, astat_wdata,
               alu_flg_en, alu_flg, mul_flg_en, mul_flg, shf_flg_en, shf_flg,
               lc_load, lc_ld_val, lc_dec,
        output astat, lce, cnd_stat, cnd_vld
    );
endinterface
`default_nettype wire

// File: rtl/ps_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ps_cond_unit
//  Description : Sequencer condition unit - ASTAT flags, sticky overflows, loop
//                counter and condition-code evaluation with optional pipelining.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps_cond_unit #(
    parameter int NFLAGS = 10,
    parameter int CNDW   = 5,
    parameter int LCW    = 16,
    parameter int PIPE   = 1,
    parameter int BYPASS = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ps_cond_unit_if.slave    bus
);
    localparam int c_az  = 0;
    localparam int c_av  = 1;
    localparam int c_an  = 2;
    localparam int c_ac  = 3;
    localparam int c_ms  = 4;
    localparam int c_mv  = 5;
    localparam int c_sv  = 6;
    localparam int c_sz  = 7;
    localparam int c_aos = 8;
    localparam int c_mos = 9;

    localparam logic [LCW-1:0] c_lc_one = {{(LCW-1){1'b0}}, 1'b1};

    logic [NFLAGS-1:0] r_astat;
    logic [LCW-1:0]    r_lc;
    logic [NFLAGS-1:0] w_astat_nxt;
    logic [LCW-1:0]    w_lc_nxt;
    logic [NFLAGS-1:0] w_src_astat;
    logic              w_src_lce;
    logic              w_mid_ok;
    logic              w_raw;
    logic              w_eval;
    logic [3:0]        w_code;
    logic              w_inv;
    logic              w_unused_flags;

    // Next-state folds hold in, so bypass evaluation under hold sees the frozen state.
    always_comb begin
        w_astat_nxt = r_astat;
        if (!bus.hold) begin
            if (bus.astat_wen) begin
                w_astat_nxt = bus.astat_wdata;
            end else begin
                if (bus.alu_flg_en) begin
                    w_astat_nxt[c_ac:c_az] = bus.alu_flg;
                    w_astat_nxt[c_aos]     = r_astat[c_aos] | bus.alu_flg[1];
                end
                if (bus.mul_flg_en) begin
                    w_astat_nxt[c_mv]  = bus.mul_flg[1];
                    w_astat_nxt[c_ms]  = bus.mul_flg[0];
                    w_astat_nxt[c_mos] = r_astat[c_mos] | bus.mul_flg[1];
                end
                if (bus.shf_flg_en) begin
                    w_astat_nxt[c_sz] = bus.shf_flg[1];
                    w_astat_nxt[c_sv] = bus.shf_flg[0];
                end
            end
        end
    end

    always_comb begin
        w_lc_nxt = r_lc;
        if (!bus.hold) begin
            if (bus.lc_load) begin
                w_lc_nxt = bus.lc_ld_val;
            end else if (bus.lc_dec && (r_lc != '0)) begin
                w_lc_nxt = r_lc - c_lc_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_astat <= '0;
            r_lc    <= '0;
        end else begin
            r_astat <= w_astat_nxt;
            r_lc    <= w_lc_nxt;
        end
    end

    assign bus.astat = r_astat;
    assign bus.lce   = (r_lc == '0);

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_src_astat = w_astat_nxt;
            assign w_src_lce   = (w_lc_nxt == '0);
        end else begin : g_registered
            assign w_src_astat = r_astat;
            assign w_src_lce   = (r_lc == '0);
        end
    endgenerate

    // Reserved code bits between the invert MSB and the 4-bit code exist only when CNDW > 5.
    generate
        if (CNDW > 5) begin : g_mid_bits
            assign w_mid_ok = ~|bus.op_cnd[CNDW-2:4];
        end else begin : g_no_mid_bits
            assign w_mid_ok = 1'b1;
        end
    endgenerate

    assign w_code = bus.op_cnd[3:0];
    assign w_inv  = bus.op_cnd[CNDW-1];

    always_comb begin
        w_raw = 1'b0;
        case (w_code)
            4'd0:    w_raw = w_src_astat[c_az];
            4'd1:    w_raw = w_src_astat[c_an];
            4'd2:    w_raw = w_src_astat[c_az] | w_src_astat[c_an];
            4'd3:    w_raw = w_src_astat[c_ac];
            4'd4:    w_raw = w_src_astat[c_av];
            4'd5:    w_raw = w_src_lce;
            4'd8:    w_raw = w_src_astat[c_mv];
            4'd9:    w_raw = w_src_astat[c_ms];
            4'd10:   w_raw = w_src_astat[c_sv];
            4'd11:   w_raw = w_src_astat[c_sz];
            default: w_raw = 1'b0;
        endcase
    end

    // All-ones is "forever": always true, the invert bit does not apply.
    assign w_eval = (&bus.op_cnd) ? 1'b1 : ((w_raw & w_mid_ok) ^ w_inv);

    // Sticky and extension bits never feed a condition code.
    assign w_unused_flags = &{1'b0, w_src_astat[NFLAGS-1:c_aos]};

    generate
        if (PIPE != 0) begin : g_pipe
            logic r_cnd_stat;
            logic r_cnd_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnd_stat <= 1'b0;
                    r_cnd_vld  <= 1'b0;
                end else if (!bus.hold) begin
                    r_cnd_stat <= bus.cnd_en & w_eval;
                    r_cnd_vld  <= bus.cnd_en;
                end
            end

            assign bus.cnd_stat = r_cnd_stat;
            assign bus.cnd_vld  = r_cnd_vld;
        end else begin : g_comb
            assign bus.cnd_stat = bus.cnd_en & w_eval;
            assign bus.cnd_vld  = bus.cnd_en;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ps_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps_cond_unit
//  Description : Directed table-driven bench for ps_cond_unit; three instances
//                (registered, bypass, combinational) share one stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps_cond_unit;
    logic clk;
    logic rst;

    logic        hold, cnd_en, astat_wen, alu_flg_en, mul_flg_en, shf_flg_en;
    logic        lc_load, lc_dec;
    logic [4:0]  op_cnd;
    logic [9:0]  astat_wdata;
    logic [3:0]  alu_flg;
    logic [1:0]  mul_flg, shf_flg;
    logic [15:0] lc_ld_val;

    int n_cmp = 0;
    int n_err = 0;

    ps_cond_unit_if #(.NFLAGS(10), .CNDW(5), .LCW(16)) if0 ();
    ps_cond_unit_if #(.NFLAGS(10), .CNDW(5), .LCW(16)) if1 ();
    ps_cond_unit_if #(.NFLAGS(10), .CNDW(5), .LCW(16)) if2 ();

`define TB_BIND(IFN) \
    assign IFN.hold = hold; assign IFN.cnd_en = cnd_en; assign IFN.op_cnd = op_cnd; \
    assign IFN.astat_wen = astat_wen; assign IFN.astat_wdata = astat_wdata; \
    assign IFN.alu_flg_en = alu_flg_en; assign IFN.alu_flg = alu_flg; \
    assign IFN.mul_flg_en = mul_flg_en; assign IFN.mul_flg = mul_flg; \
    assign IFN.shf_flg_en = shf_flg_en; assign IFN.shf_flg = shf_flg; \
    assign IFN.lc_load = lc_load; assign IFN.lc_ld_val = lc_ld_val; assign IFN.lc_dec = lc_dec;
    `TB_BIND(if0)
    `TB_BIND(if1)
    `TB_BIND(if2)
`undef TB_BIND

    ps_cond_unit #(.NFLAGS(10), .CNDW(5), .LCW(16), .PIPE(1), .BYPASS(0)) dut_reg (
        .clk(clk), .rst(rst), .bus(if0.slave));
    ps_cond_unit #(.NFLAGS(10), .CNDW(5), .LCW(16), .PIPE(1), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .bus(if1.slave));
    ps_cond_unit #(.NFLAGS(10), .CNDW(5), .LCW(16), .PIPE(0), .BYPASS(0)) dut_cmb (
        .clk(clk), .rst(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold, cen;
        logic [4:0]  op;
        logic        awen;
        logic [9:0]  awd;
        logic        aen;
        logic [3:0]  af;
        logic        men;
        logic [1:0]  mf;
        logic        sen;
        logic [1:0]  sf;
        logic        ld;
        logic [15:0] ldv;
        logic        dec;
        logic [9:0]  e_astat;
        logic        e_lce, e_s0, e_vld, e_s1, e_s2;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic h, input logic c, input logic [4:0] o, input logic aw, input logic [9:0] ad,
        input logic ae, input logic [3:0] a, input logic me, input logic [1:0] m,
        input logic se, input logic [1:0] s, input logic l, input logic [15:0] lv, input logic d,
        input logic [9:0] ea, input logic el, input logic e0, input logic ev,
        input logic e1, input logic e2);
        vec_t v;
        v.hold = h;  v.cen = c;  v.op = o;  v.awen = aw; v.awd = ad;
        v.aen = ae;  v.af = a;   v.men = me; v.mf = m;   v.sen = se; v.sf = s;
        v.ld = l;    v.ldv = lv; v.dec = d;
        v.e_astat = ea; v.e_lce = el; v.e_s0 = e0; v.e_vld = ev; v.e_s1 = e1; v.e_s2 = e2;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        hold = v.hold; cnd_en = v.cen; op_cnd = v.op;
        astat_wen = v.awen; astat_wdata = v.awd;
        alu_flg_en = v.aen; alu_flg = v.af;
        mul_flg_en = v.men; mul_flg = v.mf;
        shf_flg_en = v.sen; shf_flg = v.sf;
        lc_load = v.ld; lc_ld_val = v.ldv; lc_dec = v.dec;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          h c op     aw awd     ae af       me mf     se sf     ld ldv    dc  astat   lce s0 v s1 s2
        tv.push_back(mk(0,0,5'h00, 0,10'h000, 1,4'b0001, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h001, 1, 0,0,0,0));
        tv.push_back(mk(0,1,5'h00, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h001, 1, 1,1,1,1));
        tv.push_back(mk(0,1,5'h10, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h001, 1, 0,1,0,0));
        tv.push_back(mk(0,1,5'h1F, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h001, 1, 1,1,1,1));
        tv.push_back(mk(0,1,5'h04, 0,10'h000, 1,4'b0010, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h102, 1, 0,1,1,0));
        tv.push_back(mk(0,1,5'h04, 0,10'h000, 1,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h100, 1, 1,1,0,1));
        tv.push_back(mk(0,1,5'h08, 0,10'h000, 0,4'b0000, 1,2'b10, 1,2'b01, 0,16'd0, 0, 10'h360, 1, 0,1,1,0));
        tv.push_back(mk(0,1,5'h0A, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h360, 1, 1,1,1,1));
        tv.push_back(mk(0,1,5'h18, 1,10'h000, 1,4'b1111, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h000, 1, 0,1,1,0));
        tv.push_back(mk(0,1,5'h02, 0,10'h000, 1,4'b0100, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h004, 1, 0,1,1,0));
        tv.push_back(mk(0,1,5'h06, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h004, 1, 0,1,0,0));
        tv.push_back(mk(0,1,5'h16, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h004, 1, 1,1,1,1));
        tv.push_back(mk(0,1,5'h15, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 1,16'd3, 0, 10'h004, 0, 0,1,1,0));
        tv.push_back(mk(0,1,5'h15, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 1, 10'h004, 0, 1,1,1,1));
        tv.push_back(mk(0,1,5'h15, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 1, 10'h004, 0, 1,1,1,1));
        tv.push_back(mk(0,1,5'h15, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 1, 10'h004, 1, 1,1,0,1));
        tv.push_back(mk(0,1,5'h15, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 1, 10'h004, 1, 0,1,0,0));
        tv.push_back(mk(0,1,5'h05, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 1, 10'h004, 1, 1,1,1,1));
        tv.push_back(mk(0,0,5'h00, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 1,16'd1, 1, 10'h004, 0, 0,0,0,0));
        tv.push_back(mk(0,0,5'h00, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 1,16'd5, 1, 10'h004, 0, 0,0,0,0));
        tv.push_back(mk(0,1,5'h1F, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h004, 0, 1,1,1,1));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(1,1,5'h00, 1,10'h3FF, 1,4'b1111, 1,2'b11, 1,2'b11, 1,16'd0, 1, 10'h004, 0, 1,1,1,0));
        tv.push_back(mk(0,0,5'h00, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h004, 0, 0,0,0,0));
        tv.push_back(mk(0,1,5'h03, 0,10'h000, 1,4'b1000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h008, 0, 0,1,1,0));
        tv.push_back(mk(0,1,5'h19, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h008, 0, 1,1,1,1));
        tv.push_back(mk(0,1,5'h0B, 0,10'h000, 0,4'b0000, 0,2'b00, 1,2'b10, 0,16'd0, 0, 10'h088, 0, 0,1,1,0));
        tv.push_back(mk(0,1,5'h09, 0,10'h000, 0,4'b0000, 1,2'b01, 0,2'b00, 0,16'd0, 0, 10'h098, 0, 0,1,1,0));

        apply(mk(0,0,5'h00, 0,10'h000, 0,4'b0000, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h000, 0, 0,0,0,0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_astat", 0, 32'(if0.astat), 32'h000);
        chk("rst_lce",   0, 32'(if0.lce), 32'd1);
        chk("rst_stat",  0, 32'(if0.cnd_stat), 32'd0);
        chk("rst_vld",   0, 32'(if0.cnd_vld), 32'd0);
        chk("rst_vld_b", 0, 32'(if1.cnd_vld), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i]);
            #1;
            chk("cmb_stat", i, 32'(if2.cnd_stat), 32'(tv[i].e_s2));
            chk("cmb_vld",  i, 32'(if2.cnd_vld),  32'(tv[i].cen));
            @(posedge clk);
            #1;
            chk("astat",    i, 32'(if0.astat),    32'(tv[i].e_astat));
            chk("lce",      i, 32'(if0.lce),      32'(tv[i].e_lce));
            chk("stat",     i, 32'(if0.cnd_stat), 32'(tv[i].e_s0));
            chk("vld",      i, 32'(if0.cnd_vld),  32'(tv[i].e_vld));
            chk("byp_stat", i, 32'(if1.cnd_stat), 32'(tv[i].e_s1));
            chk("byp_vld",  i, 32'(if1.cnd_vld),  32'(tv[i].e_vld));
            chk("byp_astat", i, 32'(if1.astat),   32'(tv[i].e_astat));
        end

        // Reset arriving while an evaluation is in flight must drop the result.
        apply(mk(0,1,5'h1F, 0,10'h000, 1,4'b1111, 0,2'b00, 0,2'b00, 0,16'd0, 0, 10'h000, 0, 0,0,0,0));
        @(posedge clk);
        #1;
        chk("pre_rst_vld", 0, 32'(if0.cnd_vld), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_vld",   0, 32'(if0.cnd_vld), 32'd0);
        chk("mid_rst_stat",  0, 32'(if0.cnd_stat), 32'd0);
        chk("mid_rst_vld_b", 0, 32'(if1.cnd_vld), 32'd0);
        chk("mid_rst_astat", 0, 32'(if0.astat), 32'h000);
        chk("mid_rst_lce",   0, 32'(if0.lce), 32'd1);
        rst = 1'b0;
        cnd_en = 1'b0;
        alu_flg_en = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_vld", 0, 32'(if0.cnd_vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
